// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the execute stage and its multiply/divide unit
package mips_pkg;

  localparam int E_REGDST   = 3;
  localparam int E_ALUOP_HI = 2;
  localparam int E_ALUOP_LO = 1;
  localparam int E_ALUSRC   = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX operands, forwarding sources and EX/MEM results of the execute stage
interface ex_stage_if;
  logic [3:0]  E_in;
  logic [31:0] rd1_in;
  logic [31:0] rd2_in;
  logic [5:0]  funct_in;
  logic [4:0]  shamt_in;
  logic [31:0] immed_in;
  logic [4:0]  rs_in;
  logic [4:0]  rt_in;
  logic [4:0]  rd_in;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        zero;
  logic        stall;

  modport master (
    output E_in, rd1_in, rd2_in, funct_in, shamt_in, immed_in, rs_in, rt_in, rd_in,
    output exmem_regwrite, exmem_rd, exmem_alu, memwb_regwrite, memwb_rd, memwb_data,
    input  alu_result, store_data, dest_reg, zero, stall
  );

  modport slave (
    input  E_in, rd1_in, rd2_in, funct_in, shamt_in, immed_in, rs_in, rt_in, rd_in,
    input  exmem_regwrite, exmem_rd, exmem_alu, memwb_regwrite, memwb_rd, memwb_data,
    output alu_result, store_data, dest_reg, zero, stall
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-step multiply (and divide when EX_DIV_EN) with HI/LO
module muldiv_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef EX_DIV_EN
  input  logic        op_div,
`endif
  input  logic        op_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state;
  logic [4:0]  count;
  logic [32:0] acc;
  logic [31:0] low;
  logic [31:0] opb;
  logic        neg_res;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [63:0] prod;
  logic [63:0] prod_c;
  logic [32:0] step_acc;
  logic [31:0] step_low;
  logic [31:0] fin_hi;
  logic [31:0] fin_lo;

  assign mag_a = (op_signed && a[31]) ? -a : a;
  assign mag_b = (op_signed && b[31]) ? -b : b;
  assign busy  = (state == IDLE && start) || state == BUSY;

  // shift-add: {acc, low} is the running product, low shifts the multiplier out
  assign mul_sum = low[0] ? acc + {1'b0, opb} : acc;
  assign prod    = {mul_sum, low[31:1]};
  assign prod_c  = neg_res ? -prod : prod;

`ifdef EX_DIV_EN
  logic        div_q;
  logic        neg_rem;
  logic [31:0] a_raw;
  logic [32:0] r_sh;
  logic [33:0] diff;
  logic        q_bit;
  logic [32:0] rem_n;
  logic [31:0] quot;

  // restoring divide: acc holds the partial remainder, low shifts dividend out / quotient in
  always_comb begin
    r_sh  = {acc[31:0], low[31]};
    diff  = {1'b0, r_sh} - {2'b00, opb};
    q_bit = ~diff[33];
    rem_n = q_bit ? diff[32:0] : r_sh;
    quot  = {low[30:0], q_bit};
  end
`endif

  always_comb begin
    step_acc = {1'b0, mul_sum[32:1]};
    step_low = {mul_sum[0], low[31:1]};
    fin_hi   = prod_c[63:32];
    fin_lo   = prod_c[31:0];
`ifdef EX_DIV_EN
    if (div_q) begin
      step_acc = rem_n;
      step_low = quot;
      if (opb == 32'd0) begin
        fin_lo = 32'hFFFF_FFFF;
        fin_hi = a_raw;
      end else begin
        fin_lo = neg_res ? -quot : quot;
        fin_hi = neg_rem ? -rem_n[31:0] : rem_n[31:0];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= 5'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      acc     <= 33'd0;
      low     <= 32'd0;
      opb     <= 32'd0;
      neg_res <= 1'b0;
`ifdef EX_DIV_EN
      div_q   <= 1'b0;
      neg_rem <= 1'b0;
      a_raw   <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          acc     <= 33'd0;
          low     <= mag_a;
          opb     <= mag_b;
          neg_res <= op_signed & (a[31] ^ b[31]);
`ifdef EX_DIV_EN
          div_q   <= op_div;
          neg_rem <= op_signed & a[31];
          a_raw   <= a;
`endif
          count   <= 5'd31;
          state   <= BUSY;
        end
        BUSY: begin
          acc   <= step_acc;
          low   <= step_low;
          count <= count - 5'd1;
          if (count == 5'd0) begin
            hi    <= fin_hi;
            lo    <= fin_lo;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: forwarding, ALU, dest select, mult/div stall; EX_DIV_EN enables divide
module ex_stage
  import mips_pkg::*;
(
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);

  logic [1:0]  aluop;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] result;
  logic        md_op;
  logic        md_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  assign aluop = bus.E_in[E_ALUOP_HI:E_ALUOP_LO];

  // EX/MEM is younger than MEM/WB, so it wins when both target the same register
  always_comb begin
    fwd_a = bus.rd1_in;
    if (bus.exmem_regwrite && bus.exmem_rd != 5'd0 && bus.exmem_rd == bus.rs_in)
      fwd_a = bus.exmem_alu;
    else if (bus.memwb_regwrite && bus.memwb_rd != 5'd0 && bus.memwb_rd == bus.rs_in)
      fwd_a = bus.memwb_data;

    fwd_b = bus.rd2_in;
    if (bus.exmem_regwrite && bus.exmem_rd != 5'd0 && bus.exmem_rd == bus.rt_in)
      fwd_b = bus.exmem_alu;
    else if (bus.memwb_regwrite && bus.memwb_rd != 5'd0 && bus.memwb_rd == bus.rt_in)
      fwd_b = bus.memwb_data;
  end

  assign op_b = bus.E_in[E_ALUSRC] ? bus.immed_in : fwd_b;

  always_comb begin
    md_op = 1'b0;
    if (aluop == ALUOP_FUNCT) begin
      case (bus.funct_in)
        F_MULT, F_MULTU: md_op = 1'b1;
`ifdef EX_DIV_EN
        F_DIV, F_DIVU:   md_op = 1'b1;
`endif
        default:         md_op = 1'b0;
      endcase
    end
  end

  always_comb begin
    result = 32'd0;
    case (aluop)
      ALUOP_ADD: result = fwd_a + op_b;
      ALUOP_SUB: result = fwd_a - op_b;
      ALUOP_ORI: result = fwd_a | {16'd0, bus.immed_in[15:0]};
      default: begin
        case (bus.funct_in)
          F_ADD, F_ADDU: result = fwd_a + op_b;
          F_SUB, F_SUBU: result = fwd_a - op_b;
          F_AND:         result = fwd_a & op_b;
          F_OR:          result = fwd_a | op_b;
          F_XOR:         result = fwd_a ^ op_b;
          F_NOR:         result = ~(fwd_a | op_b);
          F_SLT:         result = {31'd0, $signed(fwd_a) < $signed(op_b)};
          F_SLTU:        result = {31'd0, fwd_a < op_b};
          F_SLL:         result = op_b << bus.shamt_in;
          F_SRL:         result = op_b >> bus.shamt_in;
          F_SRA:         result = $signed(op_b) >>> bus.shamt_in;
          F_MFHI:        result = hi;
          F_MFLO:        result = lo;
          default:       result = 32'd0;
        endcase
      end
    endcase
  end

  // funct bit 0 selects the unsigned form, bit 1 selects divide
  muldiv_unit u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_op),
`ifdef EX_DIV_EN
    .op_div    (bus.funct_in[1]),
`endif
    .op_signed (~bus.funct_in[0]),
    .a         (fwd_a),
    .b         (fwd_b),
    .busy      (md_busy),
    .hi        (hi),
    .lo        (lo)
  );

  assign bus.alu_result = rst ? 32'd0 : result;
  assign bus.store_data = rst ? 32'd0 : fwd_b;
  assign bus.dest_reg   = rst ? 5'd0 : (bus.E_in[E_REGDST] ? bus.rd_in : bus.rt_in);
  assign bus.stall      = rst ? 1'b0 : md_busy;
  assign bus.zero       = (bus.alu_result == 32'd0);

endmodule
